// File: rtl/spi_reg_responder.sv
// SPI mode-3 register-access responder: turns 17-byte host frames into
// single-cycle register write/read strobes and returns read data on smiso.
`timescale 1ns/1ps

module spi_reg_responder #(
  parameter logic [7:0]  CMD_REG  = 8'h02,
  parameter logic [7:0]  ID_BYTE  = 8'hC5,
  parameter int          SYNC_STG = 2,
  parameter logic [31:0] RD_FILL  = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ssclk,
  input  logic        scsn,
  input  logic        smosi,
  output logic        smiso,
  output logic        smiso_oe,
  output logic [5:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [31:0] reg_rdata,
  input  logic        reg_rack,
  output logic        rd_timeout,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    TAIL,
    DROP,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SYNC_STG-1:0] sclk_sync;
  logic [SYNC_STG-1:0] csn_sync;
  logic [SYNC_STG-1:0] mosi_sync;
  logic                sclk_prev;
  logic                csn_prev;
  logic                csn_armed;

  logic sclk_s;
  logic csn_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic csn_fall;
  logic csn_rise;
  logic in_frame;
  logic bit_rise;
  logic byte_done;

  logic [2:0]  bit_cnt;
  logic [4:0]  byte_cnt;
  logic [30:0] data_sr;
  logic [7:0]  rx_byte;
  logic        wr_flag;
  logic        rd_pending;
  logic [31:0] rd_word;
  logic [7:0]  tx_byte;
  logic        tx_bit;

  assign sclk_s = sclk_sync[SYNC_STG-1];
  assign csn_s  = csn_sync[SYNC_STG-1];
  assign mosi_s = mosi_sync[SYNC_STG-1];

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign csn_fall  = csn_armed & csn_prev & ~csn_s;
  assign csn_rise  = ~csn_prev & csn_s;
  assign in_frame  = (state_q != IDLE) & ~csn_s;
  assign bit_rise  = sclk_rise & in_frame;
  assign byte_done = bit_rise & (bit_cnt == 3'd7);
  assign rx_byte   = {data_sr[6:0], mosi_s};

  // Pin synchronisers and edge history; left unreset so they track the pins through reset
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STG-2:0], ssclk};
    csn_sync  <= {csn_sync[SYNC_STG-2:0], scsn};
    mosi_sync <= {mosi_sync[SYNC_STG-2:0], smosi};
    sclk_prev <= sclk_s;
    csn_prev  <= csn_s;
  end

  // A frame may only start after chip select has been seen high, so a frame cut by reset stays discarded
  always_ff @(posedge clk) begin
    if (reset) begin
      csn_armed <= 1'b0;
    end else if (csn_s) begin
      csn_armed <= 1'b1;
    end
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame sequencing: chip-select edges override everything, otherwise advance on byte boundaries
  always_comb begin
    state_d = state_q;
    if (csn_fall) begin
      state_d = CMD;
    end else if (csn_rise) begin
      state_d = IDLE;
    end else if (byte_done) begin
      case (state_q)
        CMD:     state_d = (rx_byte == CMD_REG) ? ADDR : DROP;
        ADDR:    state_d = DATA;
        DATA:    if (byte_cnt == 5'd5) state_d = TAIL;
        TAIL:    if (byte_cnt == 5'd16) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Select the outgoing frame bit: ID in byte 0, read word in bytes 10-13 of a register frame, else 0
  always_comb begin
    tx_byte = 8'h00;
    if (byte_cnt == 5'd0) begin
      tx_byte = ID_BYTE;
    end else if (state_q == TAIL) begin
      case (byte_cnt)
        5'd10:   tx_byte = rd_word[31:24];
        5'd11:   tx_byte = rd_word[23:16];
        5'd12:   tx_byte = rd_word[15:8];
        5'd13:   tx_byte = rd_word[7:0];
        default: tx_byte = 8'h00;
      endcase
    end
    tx_bit = tx_byte[3'd7 - bit_cnt];
  end

  // Bit/byte counting, command decode, strobe generation, read capture and smiso drive
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= 3'd0;
      byte_cnt   <= 5'd0;
      data_sr    <= 31'd0;
      wr_flag    <= 1'b0;
      rd_pending <= 1'b0;
      rd_word    <= 32'd0;
      reg_addr   <= 6'd0;
      reg_wdata  <= 32'd0;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      rd_timeout <= 1'b0;
      frame_err  <= 1'b0;
      smiso      <= 1'b0;
      smiso_oe   <= 1'b0;
    end else begin
      reg_wr   <= 1'b0;
      reg_rd   <= 1'b0;
      smiso_oe <= ~csn_s;
      if (csn_fall) begin
        bit_cnt    <= 3'd0;
        byte_cnt   <= 5'd0;
        wr_flag    <= 1'b0;
        rd_pending <= 1'b0;
        rd_word    <= 32'd0;
        rd_timeout <= 1'b0;
        frame_err  <= 1'b0;
        smiso      <= 1'b0;
      end else if (csn_rise) begin
        bit_cnt    <= 3'd0;
        byte_cnt   <= 5'd0;
        rd_pending <= 1'b0;
        smiso      <= 1'b0;
        if ((state_q != IDLE) && (byte_cnt < 5'd17)) begin
          frame_err <= 1'b1;
        end
      end else begin
        if (bit_rise) begin
          data_sr <= {data_sr[29:0], mosi_s};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          byte_cnt <= (byte_cnt == 5'd17) ? 5'd17 : byte_cnt + 5'd1;
          case (state_q)
            CMD: begin
              if (rx_byte != CMD_REG) begin
                frame_err <= 1'b1;
              end
            end
            ADDR: begin
              reg_addr <= rx_byte[5:0];
              wr_flag  <= rx_byte[7];
              if (!rx_byte[7]) begin
                reg_rd     <= 1'b1;
                rd_pending <= 1'b1;
              end
            end
            DATA: begin
              if ((byte_cnt == 5'd5) && wr_flag) begin
                reg_wr    <= 1'b1;
                reg_wdata <= {data_sr, mosi_s};
              end
            end
            default: begin
            end
          endcase
        end
        if (rd_pending && reg_rack) begin
          rd_word    <= reg_rdata;
          rd_pending <= 1'b0;
        end else if (rd_pending && byte_done && (byte_cnt == 5'd9)) begin
          rd_word    <= RD_FILL;
          rd_timeout <= 1'b1;
          rd_pending <= 1'b0;
        end
        if (sclk_fall && in_frame) begin
          smiso <= tx_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder: table of host frames plus a reset-mid-frame sequence.
`timescale 1ns/1ps

module tb_spi_reg_responder;

  localparam int HALF = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        ssclk;
  logic        scsn;
  logic        smosi;
  logic        smiso;
  logic        smiso_oe;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        reg_rack;
  logic        rd_timeout;
  logic        frame_err;

  spi_reg_responder dut (
    .clk       (clk),
    .reset     (reset),
    .ssclk     (ssclk),
    .scsn      (scsn),
    .smosi     (smosi),
    .smiso     (smiso),
    .smiso_oe  (smiso_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .reg_rack  (reg_rack),
    .rd_timeout(rd_timeout),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic        wr;
    logic        xbit;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          rackDly;
    int          nBytes;
    int          expWr;
    int          expRd;
    logic [5:0]  expAddr;
    logic        expErr;
    logic        expTo;
    logic [31:0] expWord;
  } vec_t;

  vec_t        vecs [9];
  logic [7:0]  txBuf [17];
  logic [7:0]  rx [17];
  logic        oeSeen;
  int          errors = 0;
  int          checks = 0;
  int          wrCount = 0;
  int          rdCount = 0;
  int          rackDelay = -1;
  logic [31:0] rdataVal = 32'd0;

  // Strobe monitor, sampled on the falling clock edge
  always @(negedge clk) begin
    if (reg_wr) wrCount++;
    if (reg_rd) rdCount++;
  end

  // Register-file stand-in: answers each reg_rd with a one-cycle rack after rackDelay cycles
  initial begin
    reg_rack  = 1'b0;
    reg_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (reg_rd && (rackDelay >= 0)) begin
        repeat (rackDelay) @(negedge clk);
        reg_rdata = rdataVal;
        reg_rack  = 1'b1;
        @(negedge clk);
        reg_rack  = 1'b0;
        reg_rdata = 32'd0;
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic buildFrame(input logic [7:0] cmd, input logic wr, input logic xbit,
                            input logic [5:0] addr, input logic [31:0] data);
    for (int i = 0; i < 17; i++) txBuf[i] = 8'h00;
    txBuf[0] = cmd;
    txBuf[1] = {wr, xbit, addr};
    txBuf[2] = data[31:24];
    txBuf[3] = data[23:16];
    txBuf[4] = data[15:8];
    txBuf[5] = data[7:0];
    txBuf[6] = 8'h5A;
    txBuf[7] = 8'hC3;
  endtask

  // Host SPI master, mode 3: drive smosi on falling ssclk, sample smiso just before rising
  task automatic applyStimulus(input int nBytes);
    for (int i = 0; i < 17; i++) rx[i] = 8'h00;
    oeSeen = 1'b0;
    @(negedge clk);
    scsn = 1'b0;
    #HALF;
    for (int b = 0; b < nBytes; b++) begin
      for (int k = 7; k >= 0; k--) begin
        ssclk = 1'b0;
        smosi = txBuf[b][k];
        #HALF;
        rx[b][k] = smiso;
        if (smiso_oe) oeSeen = 1'b1;
        ssclk = 1'b1;
        #HALF;
      end
    end
    scsn  = 1'b1;
    smosi = 1'b0;
    #200;
  endtask

  initial begin
    int wr0;
    int rd0;
    logic [7:0] restOr;

    reset = 1'b1;
    ssclk = 1'b1;
    scsn  = 1'b1;
    smosi = 1'b0;

    //               cmd    wr    x     addr   data           rdata          dly   n   wr rd expAddr err   to    expWord
    vecs[0] = '{8'h02, 1'b1, 1'b0, 6'h05, 32'h00000202, 32'h0,         -1,   17, 1, 0, 6'h05, 1'b0, 1'b0, 32'h00000000};
    vecs[1] = '{8'h02, 1'b0, 1'b0, 6'h01, 32'h0,        32'h12345678,  3,    17, 0, 1, 6'h01, 1'b0, 1'b0, 32'h12345678};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 6'h07, 32'h11223344, 32'h0,         -1,   17, 0, 0, 6'h01, 1'b1, 1'b0, 32'h00000000};
    vecs[3] = '{8'h02, 1'b1, 1'b0, 6'h2A, 32'hDEADBEEF, 32'h0,         -1,   17, 1, 0, 6'h2A, 1'b0, 1'b0, 32'h00000000};
    vecs[4] = '{8'h02, 1'b1, 1'b0, 6'h13, 32'h55667788, 32'h0,         -1,   4,  0, 0, 6'h13, 1'b1, 1'b0, 32'h00000000};
    vecs[5] = '{8'h02, 1'b1, 1'b1, 6'h3F, 32'hA5A50F0F, 32'h0,         -1,   17, 1, 0, 6'h3F, 1'b0, 1'b0, 32'h00000000};
    vecs[6] = '{8'h02, 1'b0, 1'b0, 6'h11, 32'h0,        32'h0,         -1,   17, 0, 1, 6'h11, 1'b0, 1'b1, 32'hFFFFFFFF};
    vecs[7] = '{8'h02, 1'b0, 1'b0, 6'h22, 32'h0,        32'h87654321,  1000, 17, 0, 1, 6'h22, 1'b0, 1'b1, 32'hFFFFFFFF};
    vecs[8] = '{8'h02, 1'b0, 1'b0, 6'h00, 32'h0,        32'h0BADF00D,  0,    17, 0, 1, 6'h00, 1'b0, 1'b0, 32'h0BADF00D};

    // Reset state
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_addr",  32'(reg_addr), 32'h0);
    checkOutput("reset_wdata", reg_wdata, 32'h0);
    checkOutput("reset_strb",  32'({reg_wr, reg_rd}), 32'h0);
    checkOutput("reset_flags", 32'({rd_timeout, frame_err}), 32'h0);
    checkOutput("reset_miso",  32'({smiso, smiso_oe}), 32'h0);

    // Table-driven frames
    for (int v = 0; v < 9; v++) begin
      buildFrame(vecs[v].cmd, vecs[v].wr, vecs[v].xbit, vecs[v].addr, vecs[v].data);
      rackDelay = vecs[v].rackDly;
      rdataVal  = vecs[v].rdata;
      wr0 = wrCount;
      rd0 = rdCount;
      applyStimulus(vecs[v].nBytes);
      restOr = 8'h00;
      for (int i = 1; i < 17; i++) begin
        if ((i < 10) || (i > 13)) restOr = restOr | rx[i];
      end
      $display("[TB] vector %0d done", v);
      checkOutput("wr_count",   32'(wrCount - wr0), 32'(vecs[v].expWr));
      checkOutput("rd_count",   32'(rdCount - rd0), 32'(vecs[v].expRd));
      if (vecs[v].expWr != 0) checkOutput("wdata", reg_wdata, vecs[v].data);
      checkOutput("addr",       32'(reg_addr), 32'(vecs[v].expAddr));
      checkOutput("frame_err",  32'(frame_err), 32'(vecs[v].expErr));
      checkOutput("rd_timeout", 32'(rd_timeout), 32'(vecs[v].expTo));
      checkOutput("id_byte",    32'(rx[0]), 32'hC5);
      checkOutput("rd_word",    {rx[10], rx[11], rx[12], rx[13]}, vecs[v].expWord);
      checkOutput("other_bytes", 32'(restOr), 32'h0);
      checkOutput("oe_during",  32'(oeSeen), 32'h1);
      checkOutput("oe_after",   32'(smiso_oe), 32'h0);
    end

    // Reset asserted in the middle of byte 4 of a write
    rackDelay = -1;
    buildFrame(8'h02, 1'b1, 1'b0, 6'h0C, 32'hCAFEF00D);
    wr0 = wrCount;
    fork
      applyStimulus(17);
      begin
        repeat (450) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("midrst_addr",  32'(reg_addr), 32'h0);
        checkOutput("midrst_wdata", reg_wdata, 32'h0);
        checkOutput("midrst_flags", 32'({rd_timeout, frame_err, reg_wr, reg_rd}), 32'h0);
        checkOutput("midrst_miso",  32'({smiso, smiso_oe}), 32'h0);
        reset = 1'b0;
      end
    join
    checkOutput("midrst_no_wr", 32'(wrCount - wr0), 32'h0);
    checkOutput("midrst_err",   32'(frame_err), 32'h0);

    // Next frame after release works normally
    wr0 = wrCount;
    applyStimulus(17);
    checkOutput("post_rst_wr",    32'(wrCount - wr0), 32'h1);
    checkOutput("post_rst_wdata", reg_wdata, 32'hCAFEF00D);
    checkOutput("post_rst_addr",  32'(reg_addr), 32'h0C);
    checkOutput("post_rst_err",   32'(frame_err), 32'h0);
    checkOutput("post_rst_id",    32'(rx[0]), 32'hC5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
